// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
// Imported by the arbiter top and its wait-counter watchdog.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_MEM = 2'd1,
    ACC_IF  = 2'd2
  } arb_state_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

  // Wide enough to hold the value TIMEOUT itself, so the counter can saturate there.
  function automatic int wdog_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Per-access wait counter with a sticky timeout flag.
// Cleared when the arbiter enters an access state, counts cycles spent waiting for ready.
module mem_arb_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic err
);

  localparam int CW = wdog_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          err_next;

  // Saturate at LIMIT so a very long wait cannot wrap back below it.
  always_comb begin
    cnt_next = cnt;
    if (start) begin
      cnt_next = '0;
    end else if (busy && !ready && (cnt != LIMIT)) begin
      cnt_next = cnt + 1'b1;
    end
    err_next = err | (cnt_next == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      err <= err_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, stalling the
// whole pipeline until both pending accesses of the current pipeline step are served.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic [DW-1:0] mem_rdata_o,
  output logic          stall_o,
  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  input  logic          ram_ready_i,
  output logic          err_o,
  output logic [31:0]   stall_cnt_o
);

  arb_state_t state;
  arb_state_t state_next;

  logic if_done;
  logic mem_done;
  logic mem_op;
  logic mem_need;
  logic if_need;
  logic mem_fin;
  logic if_fin;
  logic acc_start;
  logic acc_busy;

  assign mem_op   = mem_read_i | mem_write_i;
  assign mem_need = mem_op & ~mem_done;
  assign if_need  = if_req_i & ~if_done;
  assign stall_o  = mem_need | if_need;

  assign mem_fin  = (state == ACC_MEM) & ram_ready_i;
  assign if_fin   = (state == ACC_IF) & ram_ready_i;

  // Load/store is older than the fetch, so it always goes first.
  always_comb begin
    state_next  = state;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state)
      IDLE: begin
        if (mem_need) begin
          state_next = ACC_MEM;
        end else if (if_need) begin
          state_next = ACC_IF;
        end
      end
      ACC_MEM: begin
        ram_req_o   = 1'b1;
        ram_we_o    = mem_write_i;
        ram_addr_o  = mem_addr_i;
        ram_wdata_o = mem_wdata_i;
        if (ram_ready_i) begin
          state_next = if_need ? ACC_IF : IDLE;
        end
      end
      ACC_IF: begin
        ram_req_o  = 1'b1;
        ram_addr_o = if_addr_i;
        if (ram_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Done flags remember what this pipeline step already got; they drop when the pipeline advances.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
    end else if (!stall_o) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
    end else begin
      if (mem_fin) begin
        mem_done <= 1'b1;
      end
      if (if_fin) begin
        if_done <= 1'b1;
      end
    end
  end

  // A store (including read+write together) leaves the load buffer untouched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_data_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      if (mem_fin && !mem_write_i) begin
        mem_rdata_o <= ram_rdata_i;
      end
      if (if_fin) begin
        if_data_o <= ram_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  assign acc_start = (state_next != state) && (state_next != IDLE);
  assign acc_busy  = (state != IDLE);

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk   (clk_i),
    .rst_n (rst_i),
    .start (acc_start),
    .busy  (acc_busy),
    .ready (ram_ready_i),
    .err   (err_o)
  );

  // The pipeline may only advance once the arbiter has returned to IDLE.
  assert property (@(posedge clk_i) disable iff (!rst_i) !stall_o |-> (state == IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed step table, timeout and reset sequences, then
// random pipeline steps checked against a step-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
  } acc_t;

  typedef struct {
    logic        ifr;
    logic        rd;
    logic        wr;
    logic [31:0] ia;
    logic [31:0] ma;
    logic [31:0] wd;
    int          wm;
    int          wi;
    logic [31:0] e_if;
    logic [31:0] e_mrd;
    int          e_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ready_i;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bmem [logic [31:0]];
  logic        err_model;
  logic [31:0] stall_model;
  logic [31:0] prev_if;
  logic [31:0] prev_mrd;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .stall_o     (stall_o),
    .ram_req_o   (ram_req_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_ready_i (ram_ready_i),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req_i    = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    if_addr_i   = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    ram_ready_i = 1'b0;
  endtask

  // One pipeline step: call just after a rising edge; returns just after the release edge.
  task automatic run_step(input string name, input logic ifr, input logic rd, input logic wr,
                          input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                          input int wm, input int wi, input logic [31:0] e_if,
                          input logic [31:0] e_mrd, input int e_stall);
    acc_t q[$];
    acc_t a;
    int   stalls = 0;
    int   wcnt   = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;
    if (rd | wr) begin
      a.we = wr; a.addr = ma; a.wdata = wd; a.waits = wm;
      q.push_back(a);
    end
    if (ifr) begin
      a.we = 1'b0; a.addr = ia; a.wdata = '0; a.waits = wi;
      q.push_back(a);
    end
    if_req_i    = ifr;
    mem_read_i  = rd;
    mem_write_i = wr;
    if_addr_i   = ia;
    mem_addr_i  = ma;
    mem_wdata_i = wd;
    ram_ready_i = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (stall_o) stalls++;
      if (cyc == 1) chk({name, ":first_cycle_req"}, 32'(ram_req_o), 32'd0);
      if (ram_req_o) begin
        if (q.size() == 0) begin
          chk({name, ":extra_req"}, 32'(ram_req_o), 32'd0);
          ram_ready_i = 1'b0;
        end else begin
          chk({name, ":addr"}, ram_addr_o, q[0].addr);
          chk({name, ":we"}, 32'(ram_we_o), 32'(q[0].we));
          if (q[0].we) chk({name, ":wdata"}, ram_wdata_o, q[0].wdata);
          if (wcnt >= TO) err_model = 1'b1;
          if (wcnt == q[0].waits) begin
            ram_ready_i = 1'b1;
            if (q[0].we) begin
              bmem[q[0].addr] = q[0].wdata;
              ram_rdata_i = $urandom;
            end else begin
              ram_rdata_i = rd_mem(q[0].addr);
            end
            void'(q.pop_front());
            wcnt = 0;
          end else begin
            ram_ready_i = 1'b0;
            ram_rdata_i = $urandom;
            wcnt++;
          end
        end
      end else begin
        ram_ready_i = 1'b0;
        ram_rdata_i = $urandom;
      end
      chk({name, ":err"}, 32'(err_o), 32'(err_model));
      if (!stall_o) done = 1'b1;
    end
    stall_model = stall_model + 32'(e_stall);
    chk({name, ":released"}, 32'(done), 32'd1);
    chk({name, ":stall_cycles"}, 32'(stalls), 32'(e_stall));
    chk({name, ":stall_cnt"}, stall_cnt_o, stall_model);
    chk({name, ":pending_acc"}, 32'(q.size()), 32'd0);
    chk({name, ":if_data"}, if_data_o, e_if);
    chk({name, ":mem_rdata"}, mem_rdata_o, e_mrd);
    chk({name, ":bus_idle"}, 32'(ram_req_o | ram_we_o | (ram_addr_o != '0)), 32'd0);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  vec_t tbl[10];

  initial begin
    bit          ifr;
    logic [1:0]  op;
    logic [31:0] ia;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [31:0] e_if;
    logic [31:0] e_mrd;
    int          wm;
    int          wi;
    int          e_stall;
    int          seen;

    bmem[32'h0000_0000] = 32'h1111_1111;
    bmem[32'h0000_0004] = 32'h2222_2222;
    bmem[32'h0000_0008] = 32'h3333_3333;
    bmem[32'h0000_0040] = 32'h2001_0005;
    bmem[32'h0000_0044] = 32'h8C22_0000;
    bmem[32'h0000_0100] = 32'hDEAD_BEEF;

    //        ifr   rd    wr    if_addr     mem_addr    wdata         wm wi exp_if        exp_mrd       stall
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0,           0, 0, 32'h2001_0005, 32'h0000_0000, 2};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h100, 32'h0,         2, 2, 32'h8C22_0000, 32'hDEAD_BEEF, 7};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h200, 32'h1234_5678, 1, 0, 32'h1111_1111, 32'hDEAD_BEEF, 4};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0,           0, 0, 32'h2222_2222, 32'hDEAD_BEEF, 2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0,           0, 3, 32'h3333_3333, 32'hDEAD_BEEF, 5};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0,                 0, 0, 32'h3333_3333, 32'h1234_5678, 2};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                   0, 0, 32'h3333_3333, 32'h1234_5678, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h100, 32'hCAFE_F00D, 0, 0, 32'h2001_0005, 32'h1234_5678, 3};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0,                 0, 0, 32'h2001_0005, 32'hCAFE_F00D, 2};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h300, 32'h0BAD_F00D, 3, 3, 32'h2222_2222, 32'hCAFE_F00D, 9};

    rst_i       = 1'b0;
    ram_rdata_i = '0;
    clear_inputs();
    err_model   = 1'b0;
    stall_model = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:ram_req", 32'(ram_req_o), 32'd0);
    chk("reset:stall", 32'(stall_o), 32'd0);
    chk("reset:stall_cnt", stall_cnt_o, 32'd0);
    chk("reset:err", 32'(err_o), 32'd0);
    chk("reset:if_data", if_data_o, 32'd0);
    chk("reset:mem_rdata", mem_rdata_o, 32'd0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_step($sformatf("vec%0d", i), tbl[i].ifr, tbl[i].rd, tbl[i].wr, tbl[i].ia, tbl[i].ma,
               tbl[i].wd, tbl[i].wm, tbl[i].wi, tbl[i].e_if, tbl[i].e_mrd, tbl[i].e_stall);
      $display("step vec%0d if=%h mrd=%h stall_cnt=%0d", i, if_data_o, mem_rdata_o, stall_cnt_o);
    end

    // Fetch waits six cycles: err must rise after the fourth wait and stay set.
    run_step("timeout", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 6,
             32'h2001_0005, 32'hCAFE_F00D, 8);
    $display("step timeout err=%0d", err_o);
    run_step("err_sticky", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0,
             32'h2001_0005, 32'hCAFE_F00D, 0);
    $display("step err_sticky err=%0d", err_o);

    // Reset in the middle of a waiting fetch.
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (ram_req_o) seen++;
    end
    chk("rst_mid:reached_acc", 32'(seen), 32'd2);
    rst_i    = 1'b0;
    if_req_i = 1'b0;
    #1;
    chk("rst_mid:ram_req", 32'(ram_req_o), 32'd0);
    chk("rst_mid:stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_mid:err", 32'(err_o), 32'd0);
    chk("rst_mid:if_data", if_data_o, 32'd0);
    chk("rst_mid:mem_rdata", mem_rdata_o, 32'd0);
    $display("step rst_mid req=%0d err=%0d stall_cnt=%0d", ram_req_o, err_o, stall_cnt_o);
    @(negedge clk);
    rst_i       = 1'b1;
    err_model   = 1'b0;
    stall_model = '0;
    @(posedge clk);
    #1;
    run_step("rst_fetch", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 2,
             32'h2001_0005, 32'h0, 4);
    $display("step rst_fetch if=%h stall_cnt=%0d", if_data_o, stall_cnt_o);
    prev_if  = 32'h2001_0005;
    prev_mrd = 32'h0;

    for (int n = 0; n < 150; n++) begin
      ifr = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      ia  = 32'($urandom_range(0, 15)) << 2;
      ma  = 32'($urandom_range(0, 15)) << 2;
      wd  = $urandom;
      wm  = $urandom_range(0, 3);
      wi  = $urandom_range(0, 3);
      e_mrd = (op == 2'b01) ? rd_mem(ma) : prev_mrd;
      if (!ifr) e_if = prev_if;
      else if (op[1] && (ma == ia)) e_if = wd;
      else e_if = rd_mem(ia);
      e_stall = (ifr || (op != 2'b00)) ?
                1 + ((op != 2'b00) ? wm + 1 : 0) + (ifr ? wi + 1 : 0) : 0;
      run_step($sformatf("rnd%0d", n), ifr, op[0], op[1], ia, ma, wd, wm, wi, e_if, e_mrd, e_stall);
      $display("step rnd%0d if_req=%0d op=%0d if=%h mrd=%h stall_cnt=%0d",
               n, ifr, op, if_data_o, mem_rdata_o, stall_cnt_o);
      prev_if  = e_if;
      prev_mrd = e_mrd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared single-port RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined MIPS CPU.
- Raises one global stall to the pipeline: PC write disabled and all pipeline registers hold, the same way as the load-use stall, while accesses are outstanding.
- Returns fetched and loaded words from internal buffers.
- MEM stage has fixed priority over IF, because the MEM instruction is older.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles an access may wait for ram_ready_i before err_o is set

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  IF stage wants an instruction word this pipeline cycle
if_addr_i  in  AW  fetch address (PC)
if_data_o  out  DW  buffered instruction; valid when stall_o=0
mem_read_i  in  1  MEM stage load
mem_write_i  in  1  MEM stage store
mem_addr_i  in  AW  load/store address
mem_wdata_i  in  DW  store data
mem_rdata_o  out  DW  buffered load data; valid when stall_o=0
stall_o  out  1  global pipeline stall
ram_req_o  out  1  RAM access request
ram_we_o  out  1  RAM write enable
ram_addr_o  out  AW  RAM address
ram_wdata_o  out  DW  RAM write data
ram_rdata_i  in  DW  RAM read data, sampled when ram_ready_i=1
ram_ready_i  in  1  RAM completes current access this cycle
err_o  out  1  sticky timeout error
stall_cnt_o  out  32  count of cycles with stall_o=1

Behaviour:
- Reset (rst_i=0, async): state=IDLE; if_done=mem_done=0; if_data_o, mem_rdata_o, stall_cnt_o, err_o = 0; ram_req_o=0 immediately. Reset mid-access abandons the access; the RAM side must tolerate a dropped req.
- Derived signals:
  - mem_op = mem_read_i | mem_write_i
  - mem_need = mem_op & ~mem_done
  - if_need = if_req_i & ~if_done
  - stall_o = mem_need | if_need (combinational)
- FSM states: IDLE, ACC_MEM, ACC_IF.
- IDLE:
  - mem_need -> ACC_MEM
  - else if_need -> ACC_IF
  - else stay
  - ram_req_o=0
- ACC_MEM:
  - ram_req_o=1, ram_addr_o=mem_addr_i, ram_we_o=mem_write_i, ram_wdata_o=mem_wdata_i.
  - On ram_ready_i=1: mem_rdata_o<=ram_rdata_i (reads only; stores leave the buffer unchanged), mem_done<=1, next state ACC_IF if if_need else IDLE.
  - Otherwise hold.
- ACC_IF:
  - ram_req_o=1, ram_we_o=0, ram_addr_o=if_addr_i.
  - On ram_ready_i=1: if_data_o<=ram_rdata_i, if_done<=1, go IDLE.
- Outside ACC states: ram_addr_o, ram_wdata_o = 0; ram_we_o=0.
- Advance: at any edge where stall_o=0, the pipeline moves and both done flags clear. stall_o=0 implies state=IDLE.
- Address/data inputs are used live; the environment keeps them stable while stall_o=1, because the pipeline holds.
- mem_read_i and mem_write_i both high: treated as a store.
- Latency with zero-wait RAM (ready in the first ACC cycle):
  - fetch only: 3 cycles per pipeline step (IDLE, ACC_IF, release)
  - fetch plus load/store: 4 cycles (IDLE, ACC_MEM, ACC_IF, release)
- Timeout:
  - A wait counter resets on ACC-state entry and increments each ACC cycle with ram_ready_i=0.
  - Reaching TIMEOUT sets err_o=1 (sticky until reset). The access keeps waiting.
- stall_cnt_o: +1 every cycle stall_o=1, wraps at 2^32.
- No requests (if_req_i=0, mem_op=0): stall_o=0, FSM stays IDLE, no RAM traffic.

Decomposition:
- Shared package holds:
  - state typedef / localparams: IDLE=2'd0, ACC_MEM=2'd1, ACC_IF=2'd2
  - AW/DW defaults
  - TIMEOUT counter width = clog2(TIMEOUT+1)
- One natural sub-module, mem_arb_wdog: wait counter plus sticky err_o, with inputs start/busy/ready.

Test Plan:
- Reset: rst_i=0 mid ACC_IF with ram_req_o=1 -> ram_req_o=0 the same cycle, stall_cnt_o=0, err_o=0; after release with if_req_i=1, a new fetch starts from IDLE.
- Fetch only, zero-wait RAM, if_addr_i=0x0000_0040, rdata 0x2001_0005:
  - ram_req_o high in cycle 1 with addr 0x40
  - stall_o=1 in cycles 0-1, 0 in cycle 2
  - if_data_o=0x2001_0005 in cycle 2
- Load plus fetch together, RAM ready after 2 wait cycles each, mem_addr_i=0x100 returning 0xDEAD_BEEF:
  - ACC_MEM served first (addr 0x100, we=0), then ACC_IF
  - mem_rdata_o=0xDEAD_BEEF
  - stall_o drops exactly once; stall_cnt_o increases by 7
- Store: mem_write_i=1, addr 0x200, wdata 0x1234_5678 -> ram_we_o=1 with that addr/data during ACC_MEM only; mem_rdata_o unchanged; the following ACC_IF has ram_we_o=0.
- Timeout: TIMEOUT=4, ram_ready_i held 0 -> err_o rises after the 4th ACC wait cycle and stays 1 after ready returns; the access then completes normally.
- Back-to-back steps: 3 consecutive fetches 0x0, 0x4, 0x8 -> each done flag clears at release, so each address is requested exactly once and no access is duplicated.
